// File: rtl/ds1wm_bus_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : ds1wm_bus_master
//  Purpose  : Host-side sequencer for the DS1WM CPU register port. It takes
//             one register read/write command at a time on a valid/ready
//             interface. For each command it runs the multiplexed strobe
//             cycle ADS -> SETUP -> STB -> HOLD and returns one response.
//             It also synchronises the DS1WM INTR line into the CLK domain.
//  Ports    : CLK, MR (sync, active-high master reset)
//             cmd_valid/cmd_ready/cmd_wr/cmd_addr/cmd_wdata : command channel
//             rsp_valid/rsp_ready/rsp_rdata                 : response channel
//             ADDR, ADS_N, EN_N, RD_N, WR_N, DATA_O, DATA_OE, DATA_I : DS1WM bus
//             INTR (async in), irq (synchronised), busy (not IDLE)
//  Revision : 1.0  initial release
// ============================================================================
module ds1wm_bus_master #(
    parameter int T_ADS   = 1,
    parameter int T_SETUP = 1,
    parameter int T_STB   = 2,
    parameter int T_HOLD  = 1
) (
    input  logic       CLK,
    input  logic       MR,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_wr,
    input  logic [2:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic [2:0] ADDR,
    output logic       ADS_N,
    output logic       EN_N,
    output logic       RD_N,
    output logic       WR_N,
    output logic [7:0] DATA_O,
    output logic       DATA_OE,
    input  logic [7:0] DATA_I,
    input  logic       INTR,
    output logic       irq,
    output logic       busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADS   = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_STB   = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    // Phase lengths: a zero setting is treated as a single cycle.
    localparam logic [3:0] ADS_LOAD   = (T_ADS   == 0) ? 4'd1 : 4'(T_ADS);
    localparam logic [3:0] SETUP_LOAD = (T_SETUP == 0) ? 4'd1 : 4'(T_SETUP);
    localparam logic [3:0] STB_LOAD   = (T_STB   == 0) ? 4'd1 : 4'(T_STB);
    localparam logic [3:0] HOLD_LOAD  = (T_HOLD  == 0) ? 4'd1 : 4'(T_HOLD);

    logic [2:0] state;
    logic [3:0] phase_cnt;
    logic       lat_wr;
    logic [2:0] lat_addr;
    logic [7:0] lat_wdata;
    logic [7:0] rdata_q;
    logic       intr_meta;
    logic       irq_q;

    // The last cycle of a phase is the one where the down-counter reads 1.
    logic phase_done;
    assign phase_done = (phase_cnt == 4'd1);

    always_ff @(posedge CLK) begin
        if (MR) begin
            state     <= S_IDLE;
            phase_cnt <= 4'd0;
            lat_wr    <= 1'b0;
            lat_addr  <= 3'd0;
            lat_wdata <= 8'd0;
            rdata_q   <= 8'd0;
            intr_meta <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            intr_meta <= INTR;
            irq_q     <= intr_meta;

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        lat_wr    <= cmd_wr;
                        lat_addr  <= cmd_addr;
                        lat_wdata <= cmd_wdata;
                        phase_cnt <= ADS_LOAD;
                        state     <= S_ADS;
                    end
                end
                S_ADS: begin
                    if (phase_done) begin
                        phase_cnt <= SETUP_LOAD;
                        state     <= S_SETUP;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                S_SETUP: begin
                    if (phase_done) begin
                        phase_cnt <= STB_LOAD;
                        state     <= S_STB;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                S_STB: begin
                    if (phase_done) begin
                        // Read data is taken at the rising strobe edge; a
                        // write response always reports zero.
                        rdata_q   <= lat_wr ? 8'h00 : DATA_I;
                        phase_cnt <= HOLD_LOAD;
                        state     <= S_HOLD;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    if (phase_done) begin
                        phase_cnt <= 4'd0;
                        state     <= S_RESP;
                    end else begin
                        phase_cnt <= phase_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    phase_cnt <= 4'd0;
                end
            endcase
        end
    end

    logic bus_active;
    assign bus_active = (state == S_ADS) || (state == S_SETUP) ||
                        (state == S_STB) || (state == S_HOLD);

    assign cmd_ready = (state == S_IDLE);
    assign rsp_valid = (state == S_RESP);
    assign rsp_rdata = rdata_q;
    assign busy      = (state != S_IDLE);

    assign ADDR    = bus_active ? lat_addr : 3'd0;
    assign ADS_N   = (state != S_ADS);
    assign EN_N    = !((state == S_SETUP) || (state == S_STB) || (state == S_HOLD));
    assign RD_N    = !((state == S_STB) && !lat_wr);
    assign WR_N    = !((state == S_STB) &&  lat_wr);
    assign DATA_OE = lat_wr && !EN_N;
    assign DATA_O  = DATA_OE ? lat_wdata : 8'h00;

    assign irq = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_ds1wm_bus_master.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_ds1wm_bus_master
//  Purpose  : Self-checking bench for ds1wm_bus_master. Two instances are
//             used: one with the default timing and one with T_ADS=0 and
//             T_STB=4. A phase-schedule reference model predicts every bus
//             signal, cycle by cycle, for each command.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ds1wm_bus_master;

    logic       clk = 1'b0;
    logic       mr = 1'b1;
    logic       sel = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_wr = 1'b0;
    logic [2:0] cmd_addr = 3'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       rsp_ready = 1'b0;
    logic [7:0] data_i = 8'd0;
    logic       intr = 1'b0;

    always #5 clk = ~clk;

    logic       cr1, rv1, adsn1, enn1, rdn1, wrn1, oe1, irq1, busy1;
    logic [7:0] rd1, do1;
    logic [2:0] ad1;
    logic       cr2, rv2, adsn2, enn2, rdn2, wrn2, oe2, irq2, busy2;
    logic [7:0] rd2, do2;
    logic [2:0] ad2;

    ds1wm_bus_master dut (
        .CLK(clk), .MR(mr),
        .cmd_valid(cmd_valid & ~sel), .cmd_ready(cr1), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rv1), .rsp_ready(rsp_ready & ~sel), .rsp_rdata(rd1),
        .ADDR(ad1), .ADS_N(adsn1), .EN_N(enn1), .RD_N(rdn1), .WR_N(wrn1),
        .DATA_O(do1), .DATA_OE(oe1), .DATA_I(data_i),
        .INTR(intr), .irq(irq1), .busy(busy1)
    );

    ds1wm_bus_master #(.T_ADS(0), .T_SETUP(1), .T_STB(4), .T_HOLD(1)) dut2 (
        .CLK(clk), .MR(mr),
        .cmd_valid(cmd_valid & sel), .cmd_ready(cr2), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rv2), .rsp_ready(rsp_ready & sel), .rsp_rdata(rd2),
        .ADDR(ad2), .ADS_N(adsn2), .EN_N(enn2), .RD_N(rdn2), .WR_N(wrn2),
        .DATA_O(do2), .DATA_OE(oe2), .DATA_I(data_i),
        .INTR(intr), .irq(irq2), .busy(busy2)
    );

    wire       m_cr   = sel ? cr2   : cr1;
    wire       m_rv   = sel ? rv2   : rv1;
    wire       m_adsn = sel ? adsn2 : adsn1;
    wire       m_enn  = sel ? enn2  : enn1;
    wire       m_rdn  = sel ? rdn2  : rdn1;
    wire       m_wrn  = sel ? wrn2  : wrn1;
    wire       m_oe   = sel ? oe2   : oe1;
    wire       m_irq  = sel ? irq2  : irq1;
    wire       m_busy = sel ? busy2 : busy1;
    wire [7:0] m_rd   = sel ? rd2   : rd1;
    wire [7:0] m_do   = sel ? do2   : do1;
    wire [2:0] m_ad   = sel ? ad2   : ad1;

    int total  = 0;
    int passed = 0;

    // Model state: effective phase lengths of the selected instance and the
    // last response data each instance should be holding.
    int         pa, ps, pb, ph;
    logic [7:0] last_rdata [2];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    task automatic select_dut(input logic s);
        sel = s;
        if (s) begin
            pa = eff(0); ps = eff(1); pb = eff(4); ph = eff(1);
        end else begin
            pa = eff(1); ps = eff(1); pb = eff(2); ph = eff(1);
        end
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic [7:0] exp_rdata);
        chk({tag, " cmd_ready"}, {7'd0, m_cr},   8'd1);
        chk({tag, " busy"},      {7'd0, m_busy}, 8'd0);
        chk({tag, " rsp_valid"}, {7'd0, m_rv},   8'd0);
        chk({tag, " ads_n"},     {7'd0, m_adsn}, 8'd1);
        chk({tag, " en_n"},      {7'd0, m_enn},  8'd1);
        chk({tag, " rd_n"},      {7'd0, m_rdn},  8'd1);
        chk({tag, " wr_n"},      {7'd0, m_wrn},  8'd1);
        chk({tag, " data_oe"},   {7'd0, m_oe},   8'd0);
        chk({tag, " data_o"},    m_do,           8'd0);
        chk({tag, " addr"},      {5'd0, m_ad},   8'd0);
        chk({tag, " rsp_rdata"}, m_rd,           exp_rdata);
    endtask

    // Issues one command and checks every cycle against the phase schedule.
    // bp = extra cycles rsp_ready is held low in RESP; mr_at = cycle index at
    // which to pulse MR (-1 for none). Starts and ends on a falling edge.
    task automatic do_cmd(input logic wr, input logic [2:0] a, input logic [7:0] wd,
                          input logic [7:0] rv, input int bp, input int mr_at);
        int   tot;
        int   phs;
        bit   got;
        logic [7:0] new_rdata;
        string      t;
        tot = pa + ps + pb + ph;
        new_rdata = wr ? 8'h00 : rv;
        got = 1'b0;
        for (int w = 0; w < 40; w++) begin
            if (m_cr === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept_ready", {7'd0, got}, 8'd1);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = wd; rsp_ready = 1'b0;
        @(negedge clk);
        for (int j = 0; j <= tot + bp; j++) begin
            if (j < pa)                phs = 0;
            else if (j < pa + ps)      phs = 1;
            else if (j < pa + ps + pb) phs = 2;
            else if (j < tot)          phs = 3;
            else                       phs = 4;
            t = $sformatf("cyc%0d ph%0d", j, phs);
            chk({t, " ads_n"},     {7'd0, m_adsn}, {7'd0, phs != 0});
            chk({t, " en_n"},      {7'd0, m_enn},  {7'd0, !(phs >= 1 && phs <= 3)});
            chk({t, " rd_n"},      {7'd0, m_rdn},  {7'd0, !(phs == 2 && !wr)});
            chk({t, " wr_n"},      {7'd0, m_wrn},  {7'd0, !(phs == 2 && wr)});
            chk({t, " data_oe"},   {7'd0, m_oe},   {7'd0, wr && phs >= 1 && phs <= 3});
            chk({t, " data_o"},    m_do,           (wr && phs >= 1 && phs <= 3) ? wd : 8'h00);
            chk({t, " addr"},      {5'd0, m_ad},   (phs < 4) ? {5'd0, a} : 8'd0);
            chk({t, " rsp_valid"}, {7'd0, m_rv},   {7'd0, phs == 4});
            chk({t, " cmd_ready"}, {7'd0, m_cr},   8'd0);
            chk({t, " busy"},      {7'd0, m_busy}, 8'd1);
            chk({t, " rsp_rdata"}, m_rd,           (phs >= 3) ? new_rdata : last_rdata[sel]);
            if (phs < 4) begin
                cmd_valid = 1'($urandom); cmd_wr = 1'($urandom);
                cmd_addr = 3'($urandom); cmd_wdata = 8'($urandom);
                rsp_ready = 1'($urandom);
            end else begin
                cmd_valid = 1'b0;
                rsp_ready = (j == tot + bp);
            end
            data_i = (phs == 2) ? rv : (phs == 3) ? 8'hFF : 8'($urandom);
            if (j == mr_at) begin
                mr = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
                @(negedge clk);
                mr = 1'b0;
                last_rdata[sel] = 8'h00;
                chk_idle("mid_reset", 8'h00);
                chk("mid_reset irq", {7'd0, m_irq}, 8'd0);
                repeat (3) begin
                    @(negedge clk);
                    chk("mid_reset no_rsp", {7'd0, m_rv}, 8'd0);
                end
                return;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        last_rdata[sel] = new_rdata;
        chk_idle("post_rsp", new_rdata);
    endtask

    // Toggles INTR at a random point inside a cycle; irq must still show the
    // old level after the first rising edge and the new level after the second.
    task automatic intr_seq(input int n);
        logic old_v;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #($urandom_range(1, 8));
            old_v = intr;
            intr = ~intr;
            @(posedge clk); #1;
            chk("irq edge1", {7'd0, m_irq}, {7'd0, old_v});
            @(posedge clk); #1;
            chk("irq edge2", {7'd0, m_irq}, {7'd0, ~old_v});
        end
    endtask

    initial begin
        last_rdata[0] = 8'h00;
        last_rdata[1] = 8'h00;
        select_dut(1'b0);
        repeat (2) @(negedge clk);
        chk_idle("reset", 8'h00);
        chk("reset irq", {7'd0, m_irq}, 8'd0);
        select_dut(1'b1);
        chk_idle("reset dut2", 8'h00);
        select_dut(1'b0);
        @(negedge clk);
        mr = 1'b0;
        @(negedge clk);

        // Directed write and read with the default timing.
        do_cmd(1'b1, 3'd1, 8'hA5, 8'h00, 0, -1);
        do_cmd(1'b0, 3'd2, 8'h00, 8'h3C, 0, -1);
        // Response held off for 5 cycles.
        do_cmd(1'b0, 3'($urandom), 8'($urandom), 8'($urandom), 5, -1);

        // Random commands with random backpressure.
        for (int i = 0; i < 8; i++)
            do_cmd(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 3)), -1);

        // Reset during the strobe of a write, then a normal command.
        do_cmd(1'b1, 3'd5, 8'h5A, 8'h00, 0, pa + ps);
        do_cmd(1'b0, 3'd6, 8'h00, 8'hC3, 0, -1);

        // Interrupt toggles running while bus cycles proceed.
        fork
            intr_seq(6);
            begin
                do_cmd(1'b1, 3'd7, 8'h81, 8'h00, 1, -1);
                do_cmd(1'b0, 3'd3, 8'h00, 8'h42, 0, -1);
            end
        join
        @(negedge clk);

        // Instance with T_ADS=0 and T_STB=4.
        select_dut(1'b1);
        @(negedge clk);
        do_cmd(1'b0, 3'd4, 8'h00, 8'h96, 0, -1);
        for (int i = 0; i < 3; i++)
            do_cmd(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom),
                   int'($urandom_range(0, 2)), -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
